// File: rtl/spike_vote_classifier_pkg.sv
// Shared defaults and FSM encoding for the spike-count vote classifier.
package snn_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int CNT_W       = 8;
  localparam int WIN_W       = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} vote_state_e;
endpackage

// File: rtl/spike_vote_classifier_if.sv
// Handshake bundle between the network / consumer and the vote classifier.
interface spike_vote_classifier_if #(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 8,
  parameter int WIN_W       = 8
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                   ce;
  logic                   start;
  logic [WIN_W-1:0]       window_len;
  logic [NUM_CLASSES-1:0] spike_in;
  logic                   busy;
  logic                   valid_out;
  logic                   ready_in;
  logic [CLS_W-1:0]       class_out;
  logic [CNT_W-1:0]       max_count;

  modport master (output ce, start, window_len, spike_in, ready_in,
                  input  busy, valid_out, class_out, max_count);
  modport slave  (input  ce, start, window_len, spike_in, ready_in,
                  output busy, valid_out, class_out, max_count);
endinterface

// File: rtl/spike_vote_classifier_sat_counter.sv
// Per-class spike counter; sticks at all-ones instead of wrapping.
module spike_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/spike_vote_classifier.sv
// Accumulates output-layer spikes over a window, then picks the winning class
// with a one-comparator sequential argmax.
module spike_vote_classifier
  import snn_pkg::*;
#(
  parameter int NUM_CLASSES = snn_pkg::NUM_CLASSES,
  parameter int CNT_W       = snn_pkg::CNT_W,
  parameter int WIN_W       = snn_pkg::WIN_W
) (
  input logic clk,
  input logic rst_n,
  spike_vote_classifier_if.slave bus
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  vote_state_e state, state_nxt;

  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt;
  logic [WIN_W-1:0] remaining;
  logic [CLS_W-1:0] scan_idx, best_idx, class_q, win_idx;
  logic [CNT_W-1:0] best_cnt, max_q, cur_cnt, win_cnt;
  logic             accept, sample, last_idx, gt;

  assign accept   = (state == IDLE) && bus.start;
  assign sample   = (state == ACCUM) && bus.ce;
  assign last_idx = (scan_idx == CLS_W'(NUM_CLASSES - 1));
  assign cur_cnt  = cnt[scan_idx];
  // Strict compare keeps the earlier (lower) index on ties.
  assign gt       = cur_cnt > best_cnt;
  assign win_idx  = gt ? scan_idx : best_idx;
  assign win_cnt  = gt ? cur_cnt  : best_cnt;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
    spike_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .inc   (sample && bus.spike_in[g]),
      .cnt   (cnt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.window_len == '0) ? ARGMAX : ACCUM;
      ACCUM:   if (sample && (remaining == WIN_W'(1))) state_nxt = ARGMAX;
      ARGMAX:  if (last_idx) state_nxt = DONE;
      DONE:    if (bus.ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_cnt  <= '0;
      class_q   <= '0;
      max_q     <= '0;
    end else begin
      if (accept)      remaining <= bus.window_len;
      else if (sample) remaining <= remaining - 1'b1;

      // Scan registers sit at zero outside ARGMAX so every scan starts clean.
      if (state != ARGMAX) begin
        scan_idx <= '0;
        best_idx <= '0;
        best_cnt <= '0;
      end else begin
        scan_idx <= scan_idx + 1'b1;
        best_idx <= win_idx;
        best_cnt <= win_cnt;
        if (last_idx) begin
          class_q <= win_idx;
          max_q   <= win_cnt;
        end
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid_out = (state == DONE);
  assign bus.class_out = class_q;
  assign bus.max_count = max_q;
endmodule
